// File: rtl/phase_corrector.sv
// phase_corrector
//
// Per-transducer phase-offset and duty-limit stage on the clk_l drive-data
// stream. It sits between the STM/normal output mux and the modulator and
// consumes one (duty, phase) beat per valid cycle, transducer 0..DEPTH-1 in
// order. While a frame is enabled, each beat gets its calibration offset
// added modulo that transducer's cycle, and its duty is clamped to half a
// cycle. There are two pipeline stages and a fixed latency of two cycles.
//
// Ports:
//   CLK          - clk_l domain clock, the only clock
//   RESET        - synchronous, active-high reset
//   ENABLE       - 1 = correct, 0 = pass-through; latched at frame start
//   CYCLE        - per-transducer period table (quasi-static)
//   PHASE_OFFSET - per-transducer calibration offset table (quasi-static)
//   DIN_VALID    - input beat valid
//   DUTY_IN      - input duty
//   PHASE_IN     - input phase
//   DUTY_OUT     - corrected duty (holds while DOUT_VALID = 0)
//   PHASE_OUT    - corrected phase (holds while DOUT_VALID = 0)
//   DOUT_VALID   - output beat valid, DIN_VALID delayed by two cycles
//   IDX          - transducer index of the current output beat (holds)
//   FRAME_ABORT  - one-cycle pulse when a frame ends short
module phase_corrector #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        ENABLE,
    input  logic [DEPTH-1:0][WIDTH-1:0] CYCLE,
    input  logic [DEPTH-1:0][WIDTH-1:0] PHASE_OFFSET,
    input  logic                        DIN_VALID,
    input  logic [WIDTH-1:0]            DUTY_IN,
    input  logic [WIDTH-1:0]            PHASE_IN,
    output logic [WIDTH-1:0]            DUTY_OUT,
    output logic [WIDTH-1:0]            PHASE_OUT,
    output logic                        DOUT_VALID,
    output logic [7:0]                  IDX,
    output logic                        FRAME_ABORT
);

    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

    // Frame tracking
    logic [7:0]       in_idx_q, in_idx_d;
    logic             en_frame_q, en_frame_d;
    logic             abort_q, abort_d;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_duty_q, s1_duty_d;
    logic [WIDTH-1:0] s1_phase_q, s1_phase_d;
    logic [7:0]       s1_idx_q, s1_idx_d;
    logic [WIDTH-1:0] s1_cycle_q, s1_cycle_d;
    logic [WIDTH-1:0] s1_offset_q, s1_offset_d;
    logic             s1_en_q, s1_en_d;

    // Stage 2 (output) registers
    logic             dout_valid_q, dout_valid_d;
    logic [WIDTH-1:0] duty_out_q, duty_out_d;
    logic [WIDTH-1:0] phase_out_q, phase_out_d;
    logic [7:0]       idx_q, idx_d;

    // Stage 2 working values
    logic [WIDTH-1:0] off_eff_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] half_s;

    // Frame index, enable latch, abort detection and stage-1 capture
    always_comb begin
        in_idx_d    = in_idx_q;
        en_frame_d  = en_frame_q;
        abort_d     = 1'b0;
        s1_valid_d  = DIN_VALID;
        s1_duty_d   = DUTY_IN;
        s1_phase_d  = PHASE_IN;
        s1_idx_d    = in_idx_q;
        s1_cycle_d  = CYCLE[in_idx_q];
        s1_offset_d = PHASE_OFFSET[in_idx_q];
        s1_en_d     = en_frame_q;
        if (DIN_VALID) begin
            // The first beat of a frame uses the freshly sampled ENABLE.
            if (in_idx_q == 8'd0) begin
                en_frame_d = ENABLE;
                s1_en_d    = ENABLE;
            end else begin
                en_frame_d = en_frame_q;
                s1_en_d    = en_frame_q;
            end
            if (in_idx_q == LAST_IDX) begin
                in_idx_d = 8'd0;
            end else begin
                in_idx_d = in_idx_q + 8'd1;
            end
        end else begin
            // A gap inside a frame abandons it; a gap between frames is idle.
            in_idx_d = 8'd0;
            abort_d  = (in_idx_q != 8'd0);
        end
    end

    // Offset/wrap and duty clamp on the stage-1 beat; outputs hold on bubbles
    always_comb begin
        off_eff_s    = {WIDTH{1'b0}};
        sum_s        = {(WIDTH + 1){1'b0}};
        half_s       = {1'b0, s1_cycle_q[WIDTH-1:1]};
        dout_valid_d = s1_valid_q;
        duty_out_d   = duty_out_q;
        phase_out_d  = phase_out_q;
        idx_d        = idx_q;
        if (s1_valid_q) begin
            idx_d = s1_idx_q;
            if (s1_en_q) begin
                // An offset that is not below the cycle is treated as no offset.
                if (s1_offset_q < s1_cycle_q) begin
                    off_eff_s = s1_offset_q;
                end else begin
                    off_eff_s = {WIDTH{1'b0}};
                end
                sum_s = {1'b0, s1_phase_q} + {1'b0, off_eff_s};
                if (s1_phase_q >= s1_cycle_q) begin
                    phase_out_d = s1_phase_q;
                end else if (sum_s >= {1'b0, s1_cycle_q}) begin
                    // True difference is below the cycle, so truncation is exact.
                    phase_out_d = sum_s[WIDTH-1:0] - s1_cycle_q;
                end else begin
                    phase_out_d = sum_s[WIDTH-1:0];
                end
                if (s1_duty_q > half_s) begin
                    duty_out_d = half_s;
                end else begin
                    duty_out_d = s1_duty_q;
                end
            end else begin
                duty_out_d  = s1_duty_q;
                phase_out_d = s1_phase_q;
            end
        end else begin
            duty_out_d  = duty_out_q;
            phase_out_d = phase_out_q;
            idx_d       = idx_q;
        end
    end

    // All state registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_idx_q     <= 8'd0;
            en_frame_q   <= 1'b0;
            abort_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_duty_q    <= {WIDTH{1'b0}};
            s1_phase_q   <= {WIDTH{1'b0}};
            s1_idx_q     <= 8'd0;
            s1_cycle_q   <= {WIDTH{1'b0}};
            s1_offset_q  <= {WIDTH{1'b0}};
            s1_en_q      <= 1'b0;
            dout_valid_q <= 1'b0;
            duty_out_q   <= {WIDTH{1'b0}};
            phase_out_q  <= {WIDTH{1'b0}};
            idx_q        <= 8'd0;
        end else begin
            in_idx_q     <= in_idx_d;
            en_frame_q   <= en_frame_d;
            abort_q      <= abort_d;
            s1_valid_q   <= s1_valid_d;
            s1_duty_q    <= s1_duty_d;
            s1_phase_q   <= s1_phase_d;
            s1_idx_q     <= s1_idx_d;
            s1_cycle_q   <= s1_cycle_d;
            s1_offset_q  <= s1_offset_d;
            s1_en_q      <= s1_en_d;
            dout_valid_q <= dout_valid_d;
            duty_out_q   <= duty_out_d;
            phase_out_q  <= phase_out_d;
            idx_q        <= idx_d;
        end
    end

    assign DUTY_OUT    = duty_out_q;
    assign PHASE_OUT   = phase_out_q;
    assign DOUT_VALID  = dout_valid_q;
    assign IDX         = idx_q;
    assign FRAME_ABORT = abort_q;

endmodule
